arith_unit_arbiter: RTL

- Shares one `arithmetic_unit` instance (add/sub/slt/sltu, flags C/V/N/Z) between two requesters. Typical pair: execute-stage ALU path and branch-compare path.
- Valid/ready request handshake per port, round-robin arbitration, one registered result stage, response routed back to the granted requester.
- Throughput is one operation per cycle when the response side is not stalled.

---
 rtl/arith_unit_arbiter_pkg.sv | 17 +
 rtl/arith_unit_arbiter_rr_arbiter_2.sv | 25 ++
 rtl/arithmetic_unit.sv | 50 +++++
 rtl/arith_unit_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/arith_unit_arbiter_pkg.sv
// rtl/arith_unit_arbiter_pkg.sv - shared encodings for the arithmetic-unit arbiter
package arith_unit_arbiter_pkg;

  localparam logic [1:0] ARITH_ADD  = 2'b00;
  localparam logic [1:0] ARITH_SUB  = 2'b01;
  localparam logic [1:0] ARITH_SLT  = 2'b10;
  localparam logic [1:0] ARITH_SLTU = 2'b11;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/arith_unit_arbiter_rr_arbiter_2.sv
// rtl/arith_unit_arbiter_rr_arbiter_2.sv - two-way round-robin pick
module rr_arbiter_2
  import arith_unit_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  input  logic enable,
  output logic grant0,
  output logic grant1,
  output logic winner
);

  always_comb begin
    winner = REQ0;
    if (valid0 && valid1) begin
      winner = (last_grant == REQ0) ? REQ1 : REQ0;
    end else if (valid1) begin
      winner = REQ1;
    end
    grant0 = enable & valid0 & (winner == REQ0);
    grant1 = enable & valid1 & (winner == REQ1);
  end

endmodule

// File: rtl/arithmetic_unit.sv
// rtl/arithmetic_unit.sv - add/sub/slt/sltu with C/V/N/Z flags
module arithmetic_unit #(
  parameter int size = 32
) (
  input  logic [size-1:0] A,
  input  logic [size-1:0] B,
  input  logic [1:0]      Sel,
  output logic [size-1:0] S,
  output logic            C,
  output logic            V,
  output logic            N,
  output logic            Z
);

  logic            is_sub;
  logic [size-1:0] b_op;
  logic [size-1:0] sum;
  logic            carry;
  logic            lt_s;
  logic            lt_u;

  // slt/sltu reuse the subtractor; carry out is "no borrow"
  assign is_sub       = (Sel != 2'b00);
  assign b_op         = is_sub ? ~B : B;
  assign {carry, sum} = {1'b0, A} + {1'b0, b_op} + {{size{1'b0}}, is_sub};

  assign C    = carry;
  assign V    = (A[size-1] == b_op[size-1]) && (sum[size-1] != A[size-1]);
  assign lt_s = sum[size-1] ^ V;
  assign lt_u = ~carry;

  always_comb begin
    S = sum;
    N = sum[size-1];
    case (Sel)
      2'b10: begin
        N = lt_s;
        S = {{(size-1){1'b0}}, lt_s};
      end
      2'b11: begin
        N = lt_u;
        S = {{(size-1){1'b0}}, lt_u};
      end
      default: ;
    endcase
  end

  assign Z = (S == '0);

endmodule

// File: rtl/arith_unit_arbiter.sv
// rtl/arith_unit_arbiter.sv - two requesters share one arithmetic_unit, one registered result slot
// ARITH_ARB_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module arith_unit_arbiter
  import arith_unit_arbiter_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [size-1:0] req0_A,
  input  logic [size-1:0] req0_B,
  input  logic [1:0]      req0_Sel,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [size-1:0] req1_A,
  input  logic [size-1:0] req1_B,
  input  logic [1:0]      req1_Sel,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [size-1:0] rsp_S,
  output logic            rsp_C,
  output logic            rsp_V,
  output logic            rsp_N,
  output logic            rsp_Z
);

  out_state_t      state;
  out_state_t      state_next;
  logic            owner;
  logic            last_grant;
  logic            arb_last;
  logic            drain;
  logic            can_issue;
  logic            grant0;
  logic            grant1;
  logic            grant;
  logic            winner;
  logic [size-1:0] op_a;
  logic [size-1:0] op_b;
  logic [1:0]      op_sel;
  logic [size-1:0] au_s;
  logic            au_c;
  logic            au_v;
  logic            au_n;
  logic            au_z;

  assign drain     = (state == FULL) && ((owner == REQ0) ? rsp0_ready : rsp1_ready);
  assign can_issue = (state == EMPTY) || drain;

`ifdef ARITH_ARB_FIXED_PRIO_EN
  // Pretending requester 1 went last makes requester 0 win every tie.
  assign arb_last = REQ1;
`else
  assign arb_last = last_grant;
`endif

  rr_arbiter_2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (arb_last),
    .enable     (can_issue),
    .grant0     (grant0),
    .grant1     (grant1),
    .winner     (winner)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign grant      = grant0 | grant1;

  assign op_a   = grant1 ? req1_A   : req0_A;
  assign op_b   = grant1 ? req1_B   : req0_B;
  assign op_sel = grant1 ? req1_Sel : req0_Sel;

  arithmetic_unit #(.size(size)) u_alu (
    .A   (op_a),
    .B   (op_b),
    .Sel (op_sel),
    .S   (au_s),
    .C   (au_c),
    .V   (au_v),
    .N   (au_n),
    .Z   (au_z)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (grant) begin
      state_next = FULL;
    end else if (drain) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_S      <= '0;
      rsp_C      <= 1'b0;
      rsp_V      <= 1'b0;
      rsp_N      <= 1'b0;
      rsp_Z      <= 1'b0;
      owner      <= REQ0;
      last_grant <= REQ1;
    end else if (grant) begin
      rsp_S      <= au_s;
      rsp_C      <= au_c;
      rsp_V      <= au_v;
      rsp_N      <= au_n;
      rsp_Z      <= au_z;
      owner      <= winner;
      last_grant <= winner;
    end
  end

  assign rsp0_valid = (state == FULL) && (owner == REQ0);
  assign rsp1_valid = (state == FULL) && (owner == REQ1);

endmodule
